buffer_sched: RTL and testbench

BUFFER_SCHED -- requirements
Module: buffer_sched

---
 rtl/buffer_sched.sv | 154 +++++++++++++++
 tb/tb_buffer_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/buffer_sched.sv
// Double-buffer scheduler: arbitrates one shared buffer port between a display
// reader (priority) and a frame writer, and swaps buffers once a full frame is
// written and the reader is back at address 0.
// Optional feature macro: BUFFER_SCHED_STATS_EN adds the repeat_cnt output.
module buffer_sched #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned RAM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_req,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_done,
  output logic              buf_en,
  output logic              buf_swap_en,
  output logic              buf_w_en,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_din,
  input  logic [DATA_W-1:0] buf_dout
`ifdef BUFFER_SCHED_STATS_EN
  ,
  output logic [15:0]       repeat_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(RAM_DEPTH - 1);

  typedef enum logic [0:0] {StRun, StSwap} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic                r_wr_full;
  logic                r_rd_valid;
  logic                r_frame_done;
  logic                w_swap_pending;
  logic                w_rd_fire;
  logic                w_wr_fire;

  assign w_swap_pending = r_wr_full & (r_rd_addr == '0);

  // Port arbitration: swap > pending swap (port idle) > read > write.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_fire   = 1'b0;
    w_wr_fire   = 1'b0;
    wr_ready    = 1'b0;
    rd_ack      = 1'b0;
    buf_en      = 1'b0;
    buf_swap_en = 1'b0;
    buf_w_en    = 1'b0;
    buf_addr    = '0;
    buf_din     = '0;
    case (r_state)
      StRun: begin
        if (w_swap_pending) begin
          // Port left idle so the swap starts on a clean frame boundary.
          w_state_nxt = StSwap;
        end else if (rd_req) begin
          w_rd_fire = 1'b1;
          rd_ack    = 1'b1;
          buf_en    = 1'b1;
          buf_addr  = r_rd_addr;
        end else begin
          wr_ready = ~r_wr_full;
          if (wr_valid && !r_wr_full) begin
            w_wr_fire = 1'b1;
            buf_en    = 1'b1;
            buf_w_en  = 1'b1;
            buf_addr  = r_wr_addr;
            buf_din   = wr_data;
          end
        end
      end
      StSwap: begin
        buf_en      = 1'b1;
        buf_swap_en = 1'b1;
        w_state_nxt = StRun;
      end
      default: w_state_nxt = StRun;
    endcase
    // Outputs drop the moment reset asserts, not at the next edge.
    if (!rst_n) begin
      wr_ready    = 1'b0;
      rd_ack      = 1'b0;
      buf_en      = 1'b0;
      buf_swap_en = 1'b0;
      buf_w_en    = 1'b0;
      buf_addr    = '0;
      buf_din     = '0;
    end
  end

  // Read return path: buffer data lands one cycle after the issued read.
  always_comb begin
    rd_valid   = r_rd_valid;
    rd_data    = r_rd_valid ? buf_dout : '0;
    frame_done = r_frame_done;
  end

  // State, pointers and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StRun;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_wr_full    <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_valid   <= w_rd_fire;
      r_frame_done <= (r_state == StSwap);
      if (w_rd_fire) begin
        r_rd_addr <= (r_rd_addr == LastAddr) ? '0 : r_rd_addr + ADDR_W'(1);
      end
      if (r_state == StSwap) begin
        r_wr_addr <= '0;
        r_wr_full <= 1'b0;
      end else if (w_wr_fire) begin
        // Last word of a frame: hold the address, flag full.
        if (r_wr_addr == LastAddr) begin
          r_wr_full <= 1'b1;
        end else begin
          r_wr_addr <= r_wr_addr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef BUFFER_SCHED_STATS_EN
  logic [15:0] r_repeat_cnt;

  // Counts front-frame redisplays: read wraps while the writer is incomplete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_repeat_cnt <= '0;
    end else if (w_rd_fire && (r_rd_addr == LastAddr) && !r_wr_full &&
                 (r_repeat_cnt != 16'hFFFF)) begin
      r_repeat_cnt <= r_repeat_cnt + 16'd1;
    end
  end

  assign repeat_cnt = r_repeat_cnt;
`endif

endmodule

// File: tb/tb_buffer_sched.sv
// Bench for buffer_sched: directed reset/fill/contention/deferral phases plus
// random traffic, checked every cycle against a frame-level reference model.
// A ping-pong RAM model stands in for the shared buffer.
module tb_buffer_sched;

  localparam int DW    = 12;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          rd_req = 1'b0;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          frame_done;
  logic          buf_en;
  logic          buf_swap_en;
  logic          buf_w_en;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_din;
  logic [DW-1:0] buf_dout = '0;
`ifdef BUFFER_SCHED_STATS_EN
  logic [15:0]   repeat_cnt;
`endif

  buffer_sched #(.DATA_W(DW), .ADDR_W(AW), .RAM_DEPTH(DEPTH)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .buf_en     (buf_en),
    .buf_swap_en(buf_swap_en),
    .buf_w_en   (buf_w_en),
    .buf_addr   (buf_addr),
    .buf_din    (buf_din),
    .buf_dout   (buf_dout)
`ifdef BUFFER_SCHED_STATS_EN
    ,
    .repeat_cnt (repeat_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Ping-pong buffer: writes to the back bank, reads from the front bank.
  logic [DW-1:0] ram [2][DEPTH];
  logic          ram_front = 1'b0;
  always @(posedge clk) begin
    if (buf_en && buf_swap_en) ram_front <= ~ram_front;
    else if (buf_en && buf_w_en) ram[~ram_front][buf_addr] <= buf_din;
    else if (buf_en) buf_dout <= ram[ram_front][buf_addr];
  end

  // Reference model: frames as arrays, writer progress as a word count.
  logic [DW-1:0] m_front [DEPTH];
  logic [DW-1:0] m_back  [DEPTH];
  bit            m_front_known = 1'b0;
  int            m_wr_cnt = 0;
  int            m_rd_ptr = 0;
  bit            m_swapping = 1'b0;
  bit            m_done = 1'b0;
  bit            m_rv = 1'b0;
  logic [DW-1:0] m_rd_data = '0;
  bit            m_rd_known = 1'b0;
  int            m_repeats = 0;
  bit            m_last_ack = 1'b0;

  int n_vec = 0;
  int n_miscmp = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic rdy, input logic ack, input logic rv,
                                       input logic [DW-1:0] rdat, input logic fd,
                                       input logic en, input logic sw, input logic we,
                                       input logic [AW-1:0] addr, input logic [DW-1:0] din);
    return {23'b0, rdy, ack, rv, rdat, fd, en, sw, we, addr, din};
  endfunction

  // One cycle: drive inputs at negedge, compare outputs, advance the model.
  task automatic step(input string tag, input logic rst, input logic wv,
                      input logic [DW-1:0] wd, input logic rq);
    logic e_rdy, e_ack, e_en, e_sw, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rdat;
    logic [63:0] mask, got, exp;
    bit full, pend, was_swapping;
    @(negedge clk);
    rst_n = rst; wr_valid = wv; wr_data = wd; rd_req = rq;
    #1;
    {e_rdy, e_ack, e_en, e_sw, e_we} = '0;
    e_addr = '0; e_din = '0;
    full = (m_wr_cnt == DEPTH);
    pend = full && (m_rd_ptr == 0) && !m_swapping;
    if (!rst) begin
      m_wr_cnt = 0; m_rd_ptr = 0; m_swapping = 0; m_done = 0; m_rv = 0; m_repeats = 0;
      pend = 0;
    end else if (m_swapping) begin
      e_en = 1; e_sw = 1;
    end else if (pend) begin
      e_en = 0;
    end else if (rq) begin
      e_ack = 1; e_en = 1; e_addr = AW'(m_rd_ptr);
    end else if (!full) begin
      e_rdy = 1;
      if (wv) begin e_en = 1; e_we = 1; e_addr = AW'(m_wr_cnt); e_din = wd; end
    end
    e_rdat = m_rv ? m_rd_data : '0;
    mask = ~64'd0;
    if (m_rv && !m_rd_known) mask = ~(64'hFFF << 26);
    got = pack(wr_ready, rd_ack, rd_valid, rd_data, frame_done, buf_en, buf_swap_en, buf_w_en,
               buf_addr, buf_din);
    exp = pack(e_rdy, e_ack, m_rv, e_rdat, m_done, e_en, e_sw, e_we, e_addr, e_din);
    check_eq(tag, got & mask, exp & mask);
`ifdef BUFFER_SCHED_STATS_EN
    check_eq({tag, "/repeat_cnt"}, {48'b0, repeat_cnt}, 64'(m_repeats));
`endif
    m_last_ack = e_ack;
    if (!rst) return;
    was_swapping = m_swapping;
    m_done = was_swapping;
    m_rv = e_ack;
    if (e_ack) begin
      m_rd_data  = m_front[m_rd_ptr];
      m_rd_known = m_front_known;
      if (m_rd_ptr == DEPTH - 1 && !full && m_repeats < 65535) m_repeats++;
      m_rd_ptr = (m_rd_ptr + 1) % DEPTH;
    end
    if (e_we) begin
      m_back[m_wr_cnt] = wd;
      m_wr_cnt++;
    end
    if (was_swapping) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [DW-1:0] t;
        t = m_front[i]; m_front[i] = m_back[i]; m_back[i] = t;
      end
      m_front_known = 1;
      m_wr_cnt = 0;
      m_swapping = 0;
    end else if (pend) begin
      m_swapping = 1;
    end
  endtask

  initial begin
    logic rq;
    for (int i = 0; i < DEPTH; i++) begin m_front[i] = '0; m_back[i] = '0; end
    // Reset state.
    step("reset", 0, 0, '0, 0);
    step("reset", 0, 1, 12'hABC, 1);
    // Abort a partial frame at word 0x123.
    for (int i = 0; i < 'h123; i++) step("prefill", 1, 1, DW'(i), 0);
    step("mid_reset", 0, 1, 12'h5A5, 0);
    step("post_reset", 1, 1, 12'h000, 0);
    // Fill a frame (data = address) and watch the swap.
    while (m_wr_cnt < DEPTH) step("fill", 1, 1, DW'(m_wr_cnt), 0);
    for (int i = 0; i < 4; i++) step("swap", 1, 0, '0, 0);
    // Contention at rd_addr 5.
    for (int i = 0; i < 5; i++) step("reads", 1, 0, '0, 1);
    step("contend", 1, 1, 12'h777, 1);
    step("contend_rv", 1, 0, '0, 0);
    // Fill the back frame with reads parked mid-frame, then read to the wrap.
    while (m_wr_cnt < DEPTH) step("fill2", 1, 1, DW'($urandom), 0);
    for (int i = 0; i < 3; i++) step("full_idle", 1, 0, '0, 0);
    while (m_rd_ptr != 0) step("drain", 1, 0, '0, 1);
    for (int i = 0; i < 5; i++) step("defer", 1, 1, DW'($urandom), 1);
    // Random traffic; rd_req is held until acknowledged.
    rq = 0;
    for (int i = 0; i < 15000; i++) begin
      rq = (rq && !m_last_ack) ? 1'b1 : ($urandom_range(0, 99) < 35);
      step("random", 1, ($urandom_range(0, 99) < 70), DW'($urandom), rq);
    end
    // Three full read wraps with the writer idle.
    step("stats_reset", 0, 0, '0, 0);
    for (int i = 0; i < 3 * DEPTH; i++) step("repeat", 1, 0, '0, 1);
    for (int i = 0; i < 2; i++) step("repeat_end", 1, 0, '0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
